// File: rtl/arb_pkg.sv
// Shared definitions for the 4-way round-robin arbiter.
package arb_pkg;
  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;
endpackage

// File: rtl/rr_pick4.sv
// Rotating-priority pick: first set req bit at or after ptr, wrapping modulo 4.
module rr_pick4
  import arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               any,
  output logic [IDX_W-1:0]   idx
);

  logic [2*NUM_REQ-1:0] dbl;
  logic [NUM_REQ-1:0]   rot;
  logic [IDX_W-1:0]     off;

  // 4:2 priority encoder, lowest set bit wins.
  function automatic logic [IDX_W-1:0] prio_enc(input logic [NUM_REQ-1:0] v);
    prio_enc = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (v[i]) prio_enc = IDX_W'(i);
    end
  endfunction

  // Rotate so ptr lands at bit 0, encode, then rotate the index back.
  always_comb begin
    dbl = {req, req} >> ptr;
    rot = dbl[NUM_REQ-1:0];
    off = prio_enc(rot);
    any = |req;
    idx = off + ptr;
  end

endmodule

// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with bounded grant hold time.
module rr_arbiter4
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [NUM_REQ-1:0] req,
  input  logic               done,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               busy
);

  localparam int HOLD_W = 8;

  state_t             state, state_n;
  logic [IDX_W-1:0]   ptr, ptr_n;
  logic [HOLD_W-1:0]  hold_cnt, hold_n;
  logic [NUM_REQ-1:0] gnt_n;
  logic [IDX_W-1:0]   idx_n;
  logic               busy_n;
  logic               pick_any;
  logic [IDX_W-1:0]   pick_idx;
  logic               rel;

  rr_pick4 u_pick (
    .req (req),
    .ptr (ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      gnt      <= '0;
      gnt_idx  <= '0;
      busy     <= 1'b0;
      ptr      <= '0;
      hold_cnt <= '0;
    end else begin
      state    <= state_n;
      gnt      <= gnt_n;
      gnt_idx  <= idx_n;
      busy     <= busy_n;
      ptr      <= ptr_n;
      hold_cnt <= hold_n;
    end
  end

  // Any combination of release causes collapses into one release.
  assign rel = done | ~req[gnt_idx] | (hold_cnt == HOLD_W'(MAX_HOLD));

  always_comb begin
    state_n = state;
    gnt_n   = gnt;
    idx_n   = gnt_idx;
    busy_n  = busy;
    ptr_n   = ptr;
    hold_n  = hold_cnt;
    case (state)
      IDLE: begin
        if (en && pick_any) begin
          state_n = BUSY;
          gnt_n   = NUM_REQ'(1) << pick_idx;
          idx_n   = pick_idx;
          busy_n  = 1'b1;
          hold_n  = HOLD_W'(1);
        end
      end
      BUSY: begin
        // en is deliberately ignored here: disabling never cuts a grant short.
        if (rel) begin
          state_n = IDLE;
          gnt_n   = '0;
          busy_n  = 1'b0;
          ptr_n   = gnt_idx + 1'b1;
          hold_n  = '0;
        end else begin
          hold_n  = hold_cnt + HOLD_W'(1);
        end
      end
      default: begin
        state_n = IDLE;
        gnt_n   = '0;
        busy_n  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_rr_arbiter4.sv
// Scoreboard bench for rr_arbiter4: each row drives inputs and queues the outputs expected after the edge.
module tb_rr_arbiter4;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       busy;

  int vectors = 0;
  int errors  = 0;

  typedef struct {
    logic [3:0] req;
    logic       done;
    logic       en;
    logic [3:0] gnt;
    logic [1:0] idx;
    logic       busy;
  } row_t;

  row_t stim_q[$];
  row_t sb[$];

  rr_arbiter4 #(.MAX_HOLD(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .req     (req),
    .done    (done),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input logic [3:0] r, input logic d, input logic e,
                     input logic [3:0] g, input logic [1:0] i, input logic b);
    row_t x;
    x.req = r; x.done = d; x.en = e; x.gnt = g; x.idx = i; x.busy = b;
    stim_q.push_back(x);
  endtask

  task automatic do_reset();
    req = 4'b0; done = 1'b0; en = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 4'b0; done = 1'b0; en = 1'b0;
    #1;
    vectors++;
    if (gnt !== 4'b0 || gnt_idx !== 2'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: gnt=%b idx=%0d busy=%b, expected gnt=0000 idx=0 busy=0", gnt, gnt_idx, busy);
    end
    req = 4'b1111; en = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (gnt !== 4'b0 || gnt_idx !== 2'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_held: gnt=%b idx=%0d busy=%b, expected gnt=0000 idx=0 busy=0", gnt, gnt_idx, busy);
    end
    req = 4'b0; en = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    row_t s, e;
    int n = 0;
    do_reset();
    add(4'b0101, 0, 1, 4'b0001, 2'd0, 1);
    add(4'b0101, 1, 1, 4'b0000, 2'd0, 0);
    add(4'b0101, 0, 1, 4'b0100, 2'd2, 1);
    add(4'b0101, 0, 1, 4'b0100, 2'd2, 1);
    add(4'b0101, 1, 1, 4'b0000, 2'd2, 0);
    add(4'b0000, 0, 0, 4'b0000, 2'd2, 0);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      req = s.req; done = s.done; en = s.en;
      sb.push_back(s);
      @(posedge clk); #1;
      e = sb.pop_front();
      vectors++; n++;
      if (gnt !== e.gnt || gnt_idx !== e.idx || busy !== e.busy) begin
        errors++;
        $display("FAIL basic row %0d: gnt=%b idx=%0d busy=%b, expected gnt=%b idx=%0d busy=%b",
                 n, gnt, gnt_idx, busy, e.gnt, e.idx, e.busy);
      end
    end
  endtask

  task automatic test_rotation();
    row_t s, e;
    int n = 0;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      add(4'b1111, 0, 1, 4'(1) << (k % 4), 2'(k % 4), 1);
      add(4'b1111, 1, 1, 4'b0000, 2'(k % 4), 0);
    end
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      req = s.req; done = s.done; en = s.en;
      sb.push_back(s);
      @(posedge clk); #1;
      e = sb.pop_front();
      vectors++; n++;
      if (gnt !== e.gnt || gnt_idx !== e.idx || busy !== e.busy) begin
        errors++;
        $display("FAIL rotation row %0d: gnt=%b idx=%0d busy=%b, expected gnt=%b idx=%0d busy=%b",
                 n, gnt, gnt_idx, busy, e.gnt, e.idx, e.busy);
      end
    end
  endtask

  task automatic test_max_hold();
    row_t s, e;
    int n = 0;
    do_reset();
    for (int k = 0; k < 8; k++) add(4'b0010, 0, 1, 4'b0010, 2'd1, 1);
    add(4'b0010, 0, 1, 4'b0000, 2'd1, 0);
    add(4'b0010, 0, 1, 4'b0010, 2'd1, 1);
    add(4'b0010, 1, 1, 4'b0000, 2'd1, 0);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      req = s.req; done = s.done; en = s.en;
      sb.push_back(s);
      @(posedge clk); #1;
      e = sb.pop_front();
      vectors++; n++;
      if (gnt !== e.gnt || gnt_idx !== e.idx || busy !== e.busy) begin
        errors++;
        $display("FAIL max_hold row %0d: gnt=%b idx=%0d busy=%b, expected gnt=%b idx=%0d busy=%b",
                 n, gnt, gnt_idx, busy, e.gnt, e.idx, e.busy);
      end
    end
  endtask

  task automatic test_req_drop();
    row_t s, e;
    int n = 0;
    do_reset();
    add(4'b0100, 0, 1, 4'b0100, 2'd2, 1);
    add(4'b0001, 0, 1, 4'b0000, 2'd2, 0);
    add(4'b1001, 0, 1, 4'b1000, 2'd3, 1);
    add(4'b1001, 1, 1, 4'b0000, 2'd3, 0);
    add(4'b1001, 0, 1, 4'b0001, 2'd0, 1);
    add(4'b0000, 0, 1, 4'b0000, 2'd0, 0);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      req = s.req; done = s.done; en = s.en;
      sb.push_back(s);
      @(posedge clk); #1;
      e = sb.pop_front();
      vectors++; n++;
      if (gnt !== e.gnt || gnt_idx !== e.idx || busy !== e.busy) begin
        errors++;
        $display("FAIL req_drop row %0d: gnt=%b idx=%0d busy=%b, expected gnt=%b idx=%0d busy=%b",
                 n, gnt, gnt_idx, busy, e.gnt, e.idx, e.busy);
      end
    end
  endtask

  task automatic test_enable();
    row_t s, e;
    int n = 0;
    do_reset();
    for (int k = 0; k < 3; k++) add(4'b1000, 0, 0, 4'b0000, 2'd0, 0);
    add(4'b1000, 0, 1, 4'b1000, 2'd3, 1);
    for (int k = 0; k < 3; k++) add(4'b1000, 0, 0, 4'b1000, 2'd3, 1);
    add(4'b1000, 1, 0, 4'b0000, 2'd3, 0);
    add(4'b0000, 1, 1, 4'b0000, 2'd3, 0);
    add(4'b0000, 1, 1, 4'b0000, 2'd3, 0);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      req = s.req; done = s.done; en = s.en;
      sb.push_back(s);
      @(posedge clk); #1;
      e = sb.pop_front();
      vectors++; n++;
      if (gnt !== e.gnt || gnt_idx !== e.idx || busy !== e.busy) begin
        errors++;
        $display("FAIL enable row %0d: gnt=%b idx=%0d busy=%b, expected gnt=%b idx=%0d busy=%b",
                 n, gnt, gnt_idx, busy, e.gnt, e.idx, e.busy);
      end
    end
  endtask

  task automatic test_async_reset();
    row_t s, e;
    int n = 0;
    do_reset();
    add(4'b0100, 0, 1, 4'b0100, 2'd2, 1);
    add(4'b0100, 0, 1, 4'b0100, 2'd2, 1);
    add(4'b0100, 0, 1, 4'b0100, 2'd2, 1);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      req = s.req; done = s.done; en = s.en;
      sb.push_back(s);
      @(posedge clk); #1;
      e = sb.pop_front();
      vectors++; n++;
      if (gnt !== e.gnt || gnt_idx !== e.idx || busy !== e.busy) begin
        errors++;
        $display("FAIL async_reset pre row %0d: gnt=%b idx=%0d busy=%b, expected gnt=%b idx=%0d busy=%b",
                 n, gnt, gnt_idx, busy, e.gnt, e.idx, e.busy);
      end
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (gnt !== 4'b0 || gnt_idx !== 2'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_drop: gnt=%b idx=%0d busy=%b, expected gnt=0000 idx=0 busy=0", gnt, gnt_idx, busy);
    end
    req = 4'b1001; en = 1'b1; done = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (gnt !== 4'b0 || gnt_idx !== 2'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_hold: gnt=%b idx=%0d busy=%b, expected gnt=0000 idx=0 busy=0", gnt, gnt_idx, busy);
    end
    #2 rst_n = 1'b1;
    add(4'b1001, 0, 1, 4'b0001, 2'd0, 1);
    add(4'b1001, 1, 1, 4'b0000, 2'd0, 0);
    add(4'b1001, 0, 1, 4'b1000, 2'd3, 1);
    add(4'b1001, 1, 1, 4'b0000, 2'd3, 0);
    n = 0;
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      req = s.req; done = s.done; en = s.en;
      sb.push_back(s);
      @(posedge clk); #1;
      e = sb.pop_front();
      vectors++; n++;
      if (gnt !== e.gnt || gnt_idx !== e.idx || busy !== e.busy) begin
        errors++;
        $display("FAIL async_reset post row %0d: gnt=%b idx=%0d busy=%b, expected gnt=%b idx=%0d busy=%b",
                 n, gnt, gnt_idx, busy, e.gnt, e.idx, e.busy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rotation();
    test_max_hold();
    test_req_drop();
    test_enable();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/rr_arbiter4.md
RR_ARBITER4 -- requirements
Module: rr_arbiter4

Interface
REQ-001 Parameter MAX_HOLD, default 8, maximum consecutive clock cycles one grant may be held; legal range 2..255.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 en  input  1  arbiter enable; when low, no new grant is issued.
REQ-005 req  input  4  request lines; req[i] high means requester i wants the shared resource.
REQ-006 done  input  1  release strobe from the current grant holder.
REQ-007 gnt  output  4  one-hot grant, registered.
REQ-008 gnt_idx  output  2  binary index of the granted requester, registered.
REQ-009 busy  output  1  high while any grant is active, registered.

Function
REQ-010 The FSM SHALL have exactly two states: IDLE and BUSY.
REQ-011 In IDLE with en=1 and req!=0, the arbiter SHALL select the first set req bit at or after index ptr, searching ptr, ptr+1, ... modulo 4.
REQ-012 Grant latency SHALL be one cycle: if the request is sampled at edge N, then gnt, gnt_idx and busy SHALL be valid after edge N and the FSM SHALL be in BUSY.
REQ-013 gnt SHALL be one-hot or zero at all times, and gnt_idx SHALL equal the encoded position of the gnt bit whenever busy=1.
REQ-014 In IDLE with en=0 or req=0, the arbiter SHALL stay in IDLE with gnt=0 and busy=0.
REQ-015 In BUSY, gnt, gnt_idx and busy SHALL remain stable until a release event.
REQ-016 Release events SHALL be: done=1; req[gnt_idx]=0; or the hold counter reaching MAX_HOLD granted cycles.
REQ-017 Simultaneous release events SHALL be treated as a single release.
REQ-018 On release at edge M, the arbiter SHALL clear gnt and busy after edge M, set ptr to gnt_idx+1 (mod 4, so 3 wraps to 0), and return to IDLE.
REQ-019 At least one IDLE cycle SHALL separate consecutive grants; back-to-back grants are not allowed.
REQ-020 The hold counter SHALL be 1 on the first granted cycle, increment each BUSY cycle, and force release when it equals MAX_HOLD and no other release event occurs.
REQ-021 en=0 during BUSY SHALL NOT terminate the current grant.
REQ-022 done=1 while in IDLE SHALL be ignored.
REQ-023 gnt_idx SHALL hold its last value while idle.

Reset
REQ-024 Asserting rst_n low SHALL immediately force the following, regardless of clk: state=IDLE, gnt=0, gnt_idx=0, busy=0, ptr=0, hold counter=0.
REQ-025 Reset mid-grant SHALL drop the grant without any release handshake.
REQ-026 The first grant after reset SHALL give requester 0 highest priority.
REQ-027 Reset deassertion SHALL be synchronised by the surrounding system; the block SHALL NOT sample inputs during the cycle in which rst_n is low.

Structure
REQ-028 Shared package arb_pkg SHALL hold NUM_REQ=4, IDX_W=2, and the state enum {IDLE, BUSY}.
REQ-029 The rotating priority select SHALL be a combinational sub-module rr_pick4 with inputs req[3:0] and ptr[1:0] and outputs any and idx[1:0], built on a 4:2 priority encoder.
REQ-030 rr_arbiter4 SHALL contain only the FSM, ptr, hold counter and output registers.

Verification
REQ-031 Reset then req=4'b0101, en=1 -> after one edge gnt=0001, gnt_idx=0, busy=1; done pulse -> gnt=0; next grant gnt=0100, gnt_idx=2.
REQ-032 req=4'b1111 held, done pulsed each grant -> grant order 0,1,2,3,0, with exactly one idle cycle between grants.
REQ-033 MAX_HOLD=8, req=4'b0010 held, done=0 -> busy high exactly 8 cycles, then one idle cycle, then re-grant to requester 1.
REQ-034 Grant to requester 2, then req[2] drops with done=0 -> gnt=0 after that edge; ptr=3; pending req[0] is granted only after req[3] is checked.
REQ-035 en=0 with req=4'b1000 -> no grant; en=0 asserted mid-grant -> grant persists until done.
REQ-036 rst_n pulled low mid-grant between clock edges -> gnt, busy, gnt_idx=0 immediately; after release of reset with req=4'b1001, requester 0 is granted first.
